pipe_sched_ctrl: RTL
====================

Name: pipe_sched_ctrl

Overview:
Issue and write-port scheduler for the 4-stage 8-bit pipeline. It sits between decode and the MainRegister file. A per-register scoreboard decides whether the instruction in ID may issue into ID/EXE. It also generates stall and flush controls, and serialises writeback into the edge-triggered register-file write enable through a small write queue.

Parameters:
DATA_W, 8, register data width
NREG, 4, architectural registers (index width 2)
WQ_DEPTH, 2, writeback queue entries (power of 2, >=2)
CNT_W, 2, scoreboard pending-counter width (max in-flight writes per register = 2^CNT_W-1)

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  2  source register 1 index
id_rs2  in  2  source register 2 index
id_use1  in  1  instruction reads rs1
id_use2  in  1  instruction reads rs2
id_wr  in  1  instruction writes a register
id_rd  in  2  destination register index
ex_branch_taken  in  1  branch in EXE resolved taken
wb_valid  in  1  DM/WB presents a register write
wb_rd  in  2  writeback destination
wb_data  in  DATA_W  writeback value
issue  out  1  ID instruction advances this cycle (comb)
stall  out  1  hold IF/ID and PC, bubble into ID/EXE (comb)
flush_if_id  out  1  squash IF/ID (comb)
flush_id_exe  out  1  squash ID/EXE input (comb)
rf_we  out  1  register-file write pulse (registered)
rf_wd  out  2  register-file write index (registered)
rf_din  out  DATA_W  register-file write data (registered)
busy  out  1  any pending counter nonzero or queue nonempty (registered)
err  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset: all pending counters 0. Queue empty, rd/wr pointers 0. Write FSM in W_IDLE. rf_we=0, rf_wd=0, rf_din=0, busy=0, err=0. Reset may assert at any time and aborts any pulse in progress, so rf_we falls asynchronously.
- Hazard conditions, any one sufficient:
  - id_use1 and pending[id_rs1]!=0
  - id_use2 and pending[id_rs2]!=0
  - id_wr and pending[id_rd] at max
  - queue count==WQ_DEPTH
- No forwarding exists.
- stall = id_valid & hazard & ~ex_branch_taken.
- issue = id_valid & ~hazard & ~ex_branch_taken.
- flush_if_id = flush_id_exe = ex_branch_taken. Branch has priority: nothing issues and stall=0 that cycle.
- Scoreboard: at the clock edge:
  - issue & id_wr increments pending[id_rd].
  - A write pulse launch (below) decrements pending[rf_wd_next].
  - Increment and decrement on the same register leave it unchanged.
  - Decrement of 0 saturates at 0 and sets err.
- Write queue: wb_valid at edge N enqueues {wb_rd, wb_data}. If the queue is full at edge N, the entry is dropped and err is set, even if a pop occurs at the same edge.
- Write FSM, two states:
  - W_IDLE: if the queue is nonempty at the edge, pop the head. Drive rf_wd/rf_din from it, set rf_we=1, and go to W_PULSE.
  - W_PULSE: rf_we=0; go to W_IDLE.
- Minimum write latency: wb_valid sampled at edge N gives rf_we rising at edge N+1. Peak rate is one write per 2 cycles, so consecutive writes always produce distinct rising edges.
- rf_wd/rf_din hold their value after the pulse until the next launch.
- A dependent reader may issue in the cycle starting at the rf_we rising edge, because pending is decremented at that same edge.
- busy is registered from next-state counters and queue occupancy.
- err clears only on rst.

Test Plan:
- RAW stall: issue r1 write (id_wr=1, id_rd=1), next cycle id_use1=1, id_rs1=1 -> stall=1. wb_valid wb_rd=1 wb_data=8'h5A -> next edge rf_we=1, rf_wd=1, rf_din=5A, pending[1]=0. Dependent issue=1 that cycle.
- Back-to-back writeback: wb_valid 2 consecutive cycles (r2=11, r3=22) -> rf_we pattern 1,0,1,0 starting N+1. Second pulse carries rf_wd=3, rf_din=22.
- Queue full: hold FSM busy, 3 wb_valid in 3 cycles with WQ_DEPTH=2 -> stall=1 while count==2 with id_valid=1. Third write dropped only if full at that edge, and err=1.
- Branch flush: ex_branch_taken=1 with id_valid=1 and a hazard present -> flush_if_id=1, flush_id_exe=1, issue=0, stall=0. Scoreboard unchanged.
- Same-register inc/dec: issue id_rd=2 at the same edge a pulse launches for r2 with pending[2]=1 -> pending[2] stays 1, busy=1.
- Reset mid-pulse: assert rst while rf_we=1 -> rf_we=0 immediately, counters 0, queue empty, err=0. After release, no spurious rf_we.

Source files
------------

// File: rtl/pipe_sched_ctrl.sv
// pipe_sched_ctrl: scoreboard issue/stall/flush control and serialised
// register-file write scheduling through a small writeback queue.
module pipe_sched_ctrl #(
    parameter int DATA_W   = 8,
    parameter int NREG     = 4,
    parameter int WQ_DEPTH = 2,
    parameter int CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [$clog2(NREG)-1:0] id_rs1,
    input  logic [$clog2(NREG)-1:0] id_rs2,
    input  logic                    id_use1,
    input  logic                    id_use2,
    input  logic                    id_wr,
    input  logic [$clog2(NREG)-1:0] id_rd,
    input  logic                    ex_branch_taken,
    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    issue,
    output logic                    stall,
    output logic                    flush_if_id,
    output logic                    flush_id_exe,
    output logic                    rf_we,
    output logic [$clog2(NREG)-1:0] rf_wd,
    output logic [DATA_W-1:0]       rf_din,
    output logic                    busy,
    output logic                    err
);
    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(WQ_DEPTH);
    localparam logic [PW:0] QFULL = (PW+1)'(WQ_DEPTH);
    typedef enum logic {W_IDLE, W_PULSE} wstate_e;
    wstate_e state_q, state_d;
    logic [NREG-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [RW-1:0] qrd_q [WQ_DEPTH];
    logic [DATA_W-1:0] qdat_q [WQ_DEPTH];
    logic [PW-1:0] rdp_q, wrp_q;
    logic [PW:0] cnt_q, cnt_d;
    logic [NREG-1:0] inc_v, dec_v;
    logic full, push, pop, hazard, under, busy_q, err_q, we_q;
    logic [RW-1:0] wd_q;
    logic [DATA_W-1:0] din_q;
    assign full = cnt_q == QFULL;
    assign hazard = (id_use1 && pend_q[id_rs1] != '0) || (id_use2 && pend_q[id_rs2] != '0) ||
                    (id_wr && pend_q[id_rd] == '1) || full;
    assign issue = id_valid & ~hazard & ~ex_branch_taken;
    assign stall = id_valid & hazard & ~ex_branch_taken;
    assign flush_if_id = ex_branch_taken;
    assign flush_id_exe = ex_branch_taken;
    assign pop = (state_q == W_IDLE) && (cnt_q != '0);
    assign push = wb_valid & ~full;
    assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    assign inc_v = (issue && id_wr) ? NREG'(1) << id_rd : '0;
    assign dec_v = pop ? NREG'(1) << qrd_q[rdp_q] : '0;
    always_comb begin
        state_d = pop ? W_PULSE : W_IDLE;
        pend_d = pend_q;
        under = 1'b0;
        // a same-register increment and decrement cancel before saturation is considered
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = (inc_v[i] && !dec_v[i]) ? pend_q[i] + CNT_W'(1) :
                        (dec_v[i] && !inc_v[i] && pend_q[i] != '0) ? pend_q[i] - CNT_W'(1) : pend_q[i];
            under = under | (dec_v[i] && !inc_v[i] && pend_q[i] == '0);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            rdp_q  <= '0;
            wrp_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            wd_q   <= '0;
            din_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            rdp_q  <= rdp_q + PW'(pop);
            wrp_q  <= wrp_q + PW'(push);
            cnt_q  <= cnt_d;
            we_q   <= pop;
            if (pop) begin
                wd_q  <= qrd_q[rdp_q];
                din_q <= qdat_q[rdp_q];
            end
            busy_q <= (|pend_d) | (cnt_d != '0);
            err_q  <= err_q | under | (wb_valid & full);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            qrd_q[wrp_q]  <= wb_rd;
            qdat_q[wrp_q] <= wb_data;
        end
    end
    assign rf_we = we_q;
    assign rf_wd = wd_q;
    assign rf_din = din_q;
    assign busy = busy_q;
    assign err = err_q;
endmodule
